// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle for serial_subtractor.
// The master drives start and the operands; the slave returns status and results.
// With SERIAL_SUB_ADD_MODE_EN defined an extra 'op' select is carried (1 = subtract, 0 = add).
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic             op;
`endif
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
`ifdef SERIAL_SUB_ADD_MODE_EN
    output op,
`endif
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  diff,
    input  borrow,
    input  overflow
  );

  modport slave (
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  op,
`endif
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output diff,
    output borrow,
    output overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b, one bit per clock, LSB first,
// through a single full-adder cell fed with a, ~b and a running carry (initially 1).
// A start/done handshake wraps the operation; results stay registered until the next
// completion or reset.
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN adds an 'op' select (op=0 adds).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic [WIDTH-2:0] result_q;
  logic             carry_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             overflow_q;

  // subMode is 1 when the operation in flight subtracts; opIn is the request's mode
  logic             subMode;
  logic             opIn;

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic             subMode_q;
  assign subMode = subMode_q;
  assign opIn    = bus.op;
`else
  assign subMode = 1'b1;
  assign opIn    = 1'b1;
`endif

  logic             bBit_d;
  logic             sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] result_d;

  // Full-adder cell: conditionally inverted b bit, sum and majority carry
  always_comb begin
    bBit_d   = bShift_q[0] ^ subMode;
    sum_d    = aShift_q[0] ^ bBit_d ^ carry_q;
    carry_d  = (aShift_q[0] & bBit_d) | (aShift_q[0] & carry_q) | (bBit_d & carry_q);
    result_d = {sum_d, result_q};
  end

  // Control FSM and datapath registers; completion latches diff/borrow/overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      subMode_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            aShift_q <= bus.a;
            bShift_q <= bus.b;
            carry_q  <= opIn;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
`ifdef SERIAL_SUB_ADD_MODE_EN
            subMode_q <= bus.op;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          aShift_q <= {1'b0, aShift_q[WIDTH-1:1]};
          bShift_q <= {1'b0, bShift_q[WIDTH-1:1]};
          result_q <= result_d[WIDTH-1:1];
          carry_q  <= carry_d;
          count_q  <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            diff_q     <= result_d;
            borrow_q   <= carry_d ^ subMode;
            overflow_q <= carry_q ^ carry_d;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH=8) with hand-computed expectations.
// Define SERIAL_SUB_ADD_MODE_EN for both files to also exercise add mode.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Pulse start for one edge with the given operands, then scramble the operands and
  // wait (bounded) for done; lat counts edges after the accepting edge.
  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi,
                        output int lat, output int busyCnt);
    bus.start = 1'b1;
    bus.a     = ai;
    bus.b     = bi;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = ~ai;
    bus.b     = 8'hA5;
    lat       = 0;
    busyCnt   = 0;
    if (bus.busy === 1'b1) busyCnt++;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy === 1'b1) busyCnt++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done); else passes++;
    checks++; if (bus.diff !== 8'h00) $display("[TB] FAIL reset_diff: got %h expected 00", bus.diff); else passes++;
    checks++; if (bus.borrow !== 1'b0) $display("[TB] FAIL reset_borrow: got %b expected 0", bus.borrow); else passes++;
    checks++; if (bus.overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, busyCnt;
    run_op(8'h05, 8'h08, lat, busyCnt);
    checks++; if (lat !== 8) $display("[TB] FAIL basic_latency: got %0d expected 8", lat); else passes++;
    checks++; if (busyCnt !== 8) $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", busyCnt); else passes++;
    checks++; if (bus.diff !== 8'hFD) $display("[TB] FAIL basic_diff: got %h expected fd", bus.diff); else passes++;
    checks++; if (bus.borrow !== 1'b1) $display("[TB] FAIL basic_borrow: got %b expected 1", bus.borrow); else passes++;
    checks++; if (bus.overflow !== 1'b0) $display("[TB] FAIL basic_overflow: got %b expected 0", bus.overflow); else passes++;
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL basic_done_pulse: got %b expected 0", bus.done); else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.diff !== 8'hFD) $display("[TB] FAIL basic_hold_idle: got %h expected fd", bus.diff); else passes++;
  endtask

  task automatic test_flags();
    logic [7:0] va [4] = '{8'h80, 8'h37, 8'h00, 8'h7F};
    logic [7:0] vb [4] = '{8'h01, 8'h37, 8'h01, 8'hFF};
    logic [7:0] vd [4] = '{8'h7F, 8'h00, 8'hFF, 8'h80};
    logic       vbr[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       vov[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int lat, busyCnt;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat, busyCnt);
      checks++; if (bus.diff !== vd[i]) $display("[TB] FAIL flags_diff[%0d]: got %h expected %h", i, bus.diff, vd[i]); else passes++;
      checks++; if (bus.borrow !== vbr[i]) $display("[TB] FAIL flags_borrow[%0d]: got %b expected %b", i, bus.borrow, vbr[i]); else passes++;
      checks++; if (bus.overflow !== vov[i]) $display("[TB] FAIL flags_overflow[%0d]: got %b expected %b", i, bus.overflow, vov[i]); else passes++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    logic [7:0] firstDiff = 8'h00;
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    for (int c = 1; c <= 40 && d2 < 0; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin
        bus.a = 8'h20;
        bus.b = 8'h03;
      end
      if (bus.done === 1'b1) begin
        if (d1 < 0) begin
          d1 = c;
          firstDiff = bus.diff;
        end else begin
          d2 = c;
        end
      end
      if (d1 >= 0 && c == d1 + 4) begin
        checks++; if (bus.diff !== 8'h0F) $display("[TB] FAIL b2b_hold_during_op: got %h expected 0f", bus.diff); else passes++;
        checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL b2b_second_busy: got %b expected 1", bus.busy); else passes++;
      end
    end
    bus.start = 1'b0;
    checks++; if (d1 !== 9) $display("[TB] FAIL b2b_first_done_cycle: got %0d expected 9", d1); else passes++;
    checks++; if (firstDiff !== 8'h0F) $display("[TB] FAIL b2b_first_diff: got %h expected 0f", firstDiff); else passes++;
    checks++; if (d2 - d1 !== 9) $display("[TB] FAIL b2b_done_spacing: got %0d expected 9", d2 - d1); else passes++;
    checks++; if (bus.diff !== 8'h1D) $display("[TB] FAIL b2b_second_diff: got %h expected 1d", bus.diff); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    bit sawDone = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL abort_busy_before: got %b expected 1", bus.busy); else passes++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL abort_done: got %b expected 0", bus.done); else passes++;
    checks++; if (bus.diff !== 8'h00) $display("[TB] FAIL abort_diff: got %h expected 00", bus.diff); else passes++;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) sawDone = 1'b1;
    end
    checks++; if (sawDone !== 1'b0) $display("[TB] FAIL abort_no_done: got %b expected 0", sawDone); else passes++;
  endtask

  task automatic test_reset_with_start();
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'h09;
    bus.b     = 8'h02;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL rst_start_busy[%0d]: got %b expected 0", c, bus.busy); else passes++;
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL rst_start_after: got %b expected 0", bus.busy); else passes++;
  endtask

`ifdef SERIAL_SUB_ADD_MODE_EN
  task automatic test_add_mode();
    int lat, busyCnt;
    bus.op = 1'b0;
    run_op(8'hFF, 8'h01, lat, busyCnt);
    checks++; if (bus.diff !== 8'h00) $display("[TB] FAIL add_ff_01_sum: got %h expected 00", bus.diff); else passes++;
    checks++; if (bus.borrow !== 1'b1) $display("[TB] FAIL add_ff_01_carry: got %b expected 1", bus.borrow); else passes++;
    checks++; if (bus.overflow !== 1'b0) $display("[TB] FAIL add_ff_01_overflow: got %b expected 0", bus.overflow); else passes++;
    run_op(8'h7F, 8'h01, lat, busyCnt);
    checks++; if (bus.diff !== 8'h80) $display("[TB] FAIL add_7f_01_sum: got %h expected 80", bus.diff); else passes++;
    checks++; if (bus.overflow !== 1'b1) $display("[TB] FAIL add_7f_01_overflow: got %b expected 1", bus.overflow); else passes++;
    checks++; if (bus.borrow !== 1'b0) $display("[TB] FAIL add_7f_01_carry: got %b expected 0", bus.borrow); else passes++;
    bus.op = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  // Scenario sequence
  initial begin
`ifdef SERIAL_SUB_ADD_MODE_EN
    bus.op = 1'b1;
`endif
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    $display("[TB] starting serial_subtractor bench");
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
    test_reset_abort();
    test_reset_with_start();
`ifdef SERIAL_SUB_ADD_MODE_EN
    test_add_mode();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
